// File: rtl/alu_operand_sequencer.sv
// Steps an 8-bit switch bank into ALU operands A, B and Op on debounced button presses,
// then continuously captures the ALU result while in the run state.
module alu_operand_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_next,
  input  logic       btn_clear,
  input  logic [7:0] alu_y,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [2:0] Shamt,
  output logic [2:0] Op,
  output logic [1:0] state,
  output logic       valid,
  output logic [7:0] result,
  output logic       zero,
  output logic       neg
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_t;

  logic   nxt_sync1_q, nxt_sync2_q, nxt_sync3_q;
  logic   clr_sync1_q, clr_sync2_q;
  logic   next_evt;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [7:0] result_q, result_d;
  logic       valid_q, valid_d;

  // Third flop turns a held button into a single-cycle pulse.
  assign next_evt = nxt_sync2_q & ~nxt_sync3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_sync1_q <= 1'b0;
      nxt_sync2_q <= 1'b0;
      nxt_sync3_q <= 1'b0;
      clr_sync1_q <= 1'b0;
      clr_sync2_q <= 1'b0;
    end else begin
      nxt_sync1_q <= btn_next;
      nxt_sync2_q <= nxt_sync1_q;
      nxt_sync3_q <= nxt_sync2_q;
      clr_sync1_q <= btn_clear;
      clr_sync2_q <= clr_sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = valid_q;
    if (clr_sync2_q) begin
      // Any press overlapping the clear is swallowed here.
      state_d  = S_A;
      a_d      = 8'h00;
      b_d      = 8'h00;
      op_d     = 3'b000;
      result_d = 8'h00;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_A: if (next_evt) begin
          a_d     = sw;
          state_d = S_B;
        end
        S_B: if (next_evt) begin
          b_d     = sw;
          state_d = S_OP;
        end
        S_OP: if (next_evt) begin
          op_d    = sw[2:0];
          state_d = S_RUN;
        end
        S_RUN: begin
          result_d = alu_y;
          valid_d  = 1'b1;
          if (next_evt) begin
            state_d = S_A;
            valid_d = 1'b0;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_A;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'b000;
      result_q <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign Shamt  = b_q[2:0];
  assign Op     = op_q;
  assign state  = state_q;
  assign valid  = valid_q;
  assign result = result_q;
  assign zero   = (result_q == 8'h00);
  assign neg    = result_q[7];

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with an arithmetic-shift ALU model on alu_y.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn_next;
  logic       btn_clear;
  logic [7:0] alu_y;
  logic [7:0] A, B;
  logic [2:0] Shamt, Op;
  logic [1:0] state;
  logic       valid;
  logic [7:0] result;
  logic       zero, neg;

  int checks = 0;
  int passes = 0;

  alu_operand_sequencer dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
    .alu_y(alu_y), .A(A), .B(B), .Shamt(Shamt), .Op(Op), .state(state),
    .valid(valid), .result(result), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  assign alu_y = $signed(A) >>> Shamt;

  // Raise btn_next, hold past the load edge, release and let the edge detector settle.
  task automatic press(input logic [7:0] v);
    sw = v;
    btn_next = 1'b1;
    repeat (4) @(negedge clk);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; sw = 8'h00; btn_next = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'b00) $display("FAIL reset_state got %h exp 0", state); else passes++;
    checks++; if ({A, B, Op} !== 19'd0) $display("FAIL reset_regs got A=%h B=%h Op=%h exp 0", A, B, Op); else passes++;
    checks++; if ({valid, result} !== 9'd0) $display("FAIL reset_result got valid=%b result=%h exp 0", valid, result); else passes++;
    checks++; if ({zero, neg} !== 2'b10) $display("FAIL reset_flags got zero=%b neg=%b exp 1 0", zero, neg); else passes++;
  endtask

  task automatic test_sequence;
    press(8'hF0);
    checks++; if (state !== 2'b01 || A !== 8'hF0) $display("FAIL seq_a got state=%h A=%h exp 1 F0", state, A); else passes++;
    press(8'h02);
    checks++; if (state !== 2'b10 || B !== 8'h02) $display("FAIL seq_b got state=%h B=%h exp 2 02", state, B); else passes++;
    sw = 8'h05;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'b11 || Op !== 3'd5 || Shamt !== 3'd2) $display("FAIL seq_op got state=%h Op=%0d Shamt=%0d exp 3 5 2", state, Op, Shamt); else passes++;
    checks++; if (valid !== 1'b0) $display("FAIL seq_valid_early got %b exp 0", valid); else passes++;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || result !== 8'hFC) $display("FAIL seq_capture got valid=%b result=%h exp 1 FC", valid, result); else passes++;
    checks++; if (neg !== 1'b1 || zero !== 1'b0) $display("FAIL seq_flags got neg=%b zero=%b exp 1 0", neg, zero); else passes++;
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_run_exit;
    sw = 8'h99;
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'b11 || valid !== 1'b1) $display("FAIL exit_before got state=%h valid=%b exp 3 1", state, valid); else passes++;
    @(negedge clk);
    checks++; if (state !== 2'b00 || valid !== 1'b0) $display("FAIL exit_after got state=%h valid=%b exp 0 0", state, valid); else passes++;
    checks++; if (result !== 8'hFC || A !== 8'hF0) $display("FAIL exit_hold got result=%h A=%h exp FC F0", result, A); else passes++;
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold;
    sw = 8'h11;
    btn_next = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (state !== 2'b01 || A !== 8'h11) $display("FAIL hold_once got state=%h A=%h exp 1 11", state, A); else passes++;
    checks++; if (B !== 8'h02) $display("FAIL hold_b got B=%h exp 02", B); else passes++;
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear;
    press(8'h03);
    press(8'h06);
    checks++; if (state !== 2'b11 || valid !== 1'b1) $display("FAIL clear_pre got state=%h valid=%b exp 3 1", state, valid); else passes++;
    btn_clear = 1'b1;
    btn_next = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (state !== 2'b00) $display("FAIL clear_state got %h exp 0", state); else passes++;
    checks++; if ({A, B, Op, result} !== 27'd0) $display("FAIL clear_regs got A=%h B=%h Op=%h result=%h exp 0", A, B, Op, result); else passes++;
    checks++; if (valid !== 1'b0 || zero !== 1'b1) $display("FAIL clear_flags got valid=%b zero=%b exp 0 1", valid, zero); else passes++;
    btn_clear = 1'b0;
    repeat (6) @(negedge clk);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'b00 || A !== 8'h00) $display("FAIL clear_consumed got state=%h A=%h exp 0 00", state, A); else passes++;
  endtask

  task automatic test_edge_timing;
    sw = 8'h3C;
    btn_next = 1'b1;
    @(negedge clk);
    checks++; if (A !== 8'h00) $display("FAIL edge_k got A=%h exp 00", A); else passes++;
    @(negedge clk);
    checks++; if (A !== 8'h00) $display("FAIL edge_k1 got A=%h exp 00", A); else passes++;
    @(negedge clk);
    checks++; if (A !== 8'h3C || state !== 2'b01) $display("FAIL edge_k2 got A=%h state=%h exp 3C 1", A, state); else passes++;
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    sw = 8'hAA;
    repeat (5) @(negedge clk);
    checks++; if (A !== 8'h3C || B !== 8'h00 || state !== 2'b01) $display("FAIL sw_ignored got A=%h B=%h state=%h exp 3C 00 1", A, B, state); else passes++;
  endtask

  task automatic test_mid_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    press(8'h80);
    press(8'h07);
    checks++; if (state !== 2'b10 || A !== 8'h80 || B !== 8'h07) $display("FAIL mrst_pre got state=%h A=%h B=%h exp 2 80 07", state, A, B); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({state, A, B, Shamt, Op, valid, result} !== 33'd0) $display("FAIL mrst_clear got state=%h A=%h B=%h Op=%h valid=%b result=%h exp 0", state, A, B, Op, valid, result); else passes++;
    press(8'h40);
    press(8'h03);
    press(8'h01);
    checks++; if (state !== 2'b11 || Op !== 3'd1 || Shamt !== 3'd3) $display("FAIL mrst_seq got state=%h Op=%0d Shamt=%0d exp 3 1 3", state, Op, Shamt); else passes++;
    checks++; if (valid !== 1'b1 || result !== 8'h08 || neg !== 1'b0 || zero !== 1'b0) $display("FAIL mrst_result got valid=%b result=%h neg=%b zero=%b exp 1 08 0 0", valid, result, neg, zero); else passes++;
  endtask

  task automatic test_reset_release;
    rst = 1'b1;
    sw = 8'h5A;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'b00 || valid !== 1'b0) $display("FAIL rel_in_reset got state=%h valid=%b exp 0 0", state, valid); else passes++;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (state !== 2'b01 || A !== 8'h5A || B !== 8'h00) $display("FAIL rel_one_evt got state=%h A=%h B=%h exp 1 5A 00", state, A, B); else passes++;
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_run_exit;
    test_hold;
    test_clear;
    test_edge_timing;
    test_mid_reset;
    test_reset_release;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
